// File: rtl/life_pkg.sv
// Shared types and constants for the Game of Life engine.
//   state_t        : run FSM states
//   RULE_W / NBR_W : rule-mask width and neighbour-count width
//   CONWAY_*       : B3/S23 rule masks
//   count_live     : population count of the eight neighbour bits
package life_pkg;

    localparam int unsigned RULE_W = 9;
    localparam int unsigned NBR_W  = 4;
    localparam int unsigned NBR_N  = 8;

    localparam logic [RULE_W-1:0] CONWAY_BIRTH   = 9'b0_0000_1000;
    localparam logic [RULE_W-1:0] CONWAY_SURVIVE = 9'b0_0000_1100;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Number of live neighbours, 0..8.
    function automatic logic [NBR_W-1:0] count_live(input logic [NBR_N-1:0] nbr);
        logic [NBR_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < int'(NBR_N); i++) begin
            cnt = cnt + NBR_W'(nbr[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/life_rule_cell.sv
// Combinational next state of one cell.
//   alive        : current state of this cell
//   nbr          : the eight neighbour states
//   birth_rule   : bit n set -> dead cell with n neighbours is born
//   survive_rule : bit n set -> live cell with n neighbours survives
//   next_c       : state of this cell in the next generation
module life_rule_cell
    import life_pkg::*;
(
    input  logic                alive,
    input  logic [NBR_N-1:0]    nbr,
    input  logic [RULE_W-1:0]   birth_rule,
    input  logic [RULE_W-1:0]   survive_rule,
    output logic                next_c
);

    logic [NBR_W-1:0] cnt;

    assign cnt    = count_live(nbr);
    assign next_c = alive ? survive_rule[cnt] : birth_rule[cnt];

endmodule

// File: rtl/life_grid.sv
// Game of Life engine: ROWS x COLS cell register advanced one generation per
// enabled RUN cycle, with a run FSM that stops on target count, still life or
// extinction.
//   clk, rst            : clock, asynchronous active-high reset
//   ena                 : step enable while running
//   load_valid/row/data : host row write (IDLE only)
//   birth/survive_rule  : rule masks, captured on start
//   gen_target, start   : run request (IDLE only)
//   grid_q              : current grid, bit r*COLS+c
//   busy, done          : running / one-cycle end-of-run pulse
//   stable, extinct     : reason the last run ended
//   gen_count           : generations committed in current/last run
module life_grid
    import life_pkg::*;
#(
    parameter int unsigned ROWS  = 8,
    parameter int unsigned COLS  = 8,
    parameter bit          WRAP  = 1'b1,
    parameter int unsigned GEN_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ena,
    input  logic                    load_valid,
    input  logic [$clog2(ROWS)-1:0] load_row,
    input  logic [COLS-1:0]         load_data,
    input  logic [RULE_W-1:0]       birth_rule,
    input  logic [RULE_W-1:0]       survive_rule,
    input  logic [GEN_W-1:0]        gen_target,
    input  logic                    start,
    output logic [ROWS*COLS-1:0]    grid_q,
    output logic                    busy,
    output logic                    done,
    output logic                    stable,
    output logic                    extinct,
    output logic [GEN_W-1:0]        gen_count
);

    localparam int unsigned CELLS = ROWS * COLS;
    localparam int unsigned ROW_W = $clog2(ROWS);
    localparam int          NR    = int'(ROWS);
    localparam int          NC    = int'(COLS);

    state_t              state_q, state_d;
    logic [CELLS-1:0]    grid_d, next_grid;
    logic [GEN_W-1:0]    gen_d, gen_inc, target_q, target_d;
    logic [RULE_W-1:0]   birth_q, birth_d, survive_q, survive_d;
    logic                busy_d, done_d, stable_d, extinct_d;
    logic                still_c, empty_c;

    // Per-cell neighbourhood wiring, resolved at elaboration time.
    for (genvar r = 0; r < NR; r++) begin : g_row
        for (genvar c = 0; c < NC; c++) begin : g_col
            logic [NBR_N-1:0] nbr;
            for (genvar k = 0; k < 9; k++) begin : g_nbr
                if (k != 4) begin : g_tap
                    localparam int RR  = r + k / 3 - 1;
                    localparam int CC  = c + k % 3 - 1;
                    localparam int BIT = (k < 4) ? k : k - 1;
                    if (WRAP) begin : g_wrap
                        assign nbr[BIT] = grid_q[((RR + NR) % NR) * NC + ((CC + NC) % NC)];
                    end else if (RR < 0 || RR >= NR || CC < 0 || CC >= NC) begin : g_edge
                        assign nbr[BIT] = 1'b0;
                    end else begin : g_in
                        assign nbr[BIT] = grid_q[RR * NC + CC];
                    end
                end
            end
            life_rule_cell u_cell (
                .alive        (grid_q[r * NC + c]),
                .nbr          (nbr),
                .birth_rule   (birth_q),
                .survive_rule (survive_q),
                .next_c       (next_grid[r * NC + c])
            );
        end
    end

    assign still_c = (next_grid == grid_q);
    assign empty_c = (next_grid == '0);
    assign gen_inc = gen_count + GEN_W'(1);

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            grid_q    <= '0;
            gen_count <= '0;
            target_q  <= '0;
            birth_q   <= CONWAY_BIRTH;
            survive_q <= CONWAY_SURVIVE;
            busy      <= 1'b0;
            done      <= 1'b0;
            stable    <= 1'b0;
            extinct   <= 1'b0;
        end else begin
            state_q   <= state_d;
            grid_q    <= grid_d;
            gen_count <= gen_d;
            target_q  <= target_d;
            birth_q   <= birth_d;
            survive_q <= survive_d;
            busy      <= busy_d;
            done      <= done_d;
            stable    <= stable_d;
            extinct   <= extinct_d;
        end
    end

    // Next state: host loads and run start in IDLE, generation commits in RUN.
    always_comb begin
        state_d   = state_q;
        grid_d    = grid_q;
        gen_d     = gen_count;
        target_d  = target_q;
        birth_d   = birth_q;
        survive_d = survive_q;
        done_d    = 1'b0;
        stable_d  = stable;
        extinct_d = extinct;

        unique case (state_q)
            IDLE: begin
                // Row indices >= ROWS match no row and are dropped.
                if (load_valid) begin
                    for (int r = 0; r < NR; r++) begin
                        if (load_row == ROW_W'(r)) begin
                            grid_d[r * NC +: NC] = load_data;
                        end
                    end
                end
                if (start) begin
                    target_d  = gen_target;
                    birth_d   = birth_rule;
                    survive_d = survive_rule;
                    gen_d     = '0;
                    stable_d  = 1'b0;
                    extinct_d = 1'b0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (ena) begin
                    if (target_q == '0) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        grid_d = next_grid;
                        gen_d  = gen_inc;
                        if (gen_inc == target_q || still_c || empty_c) begin
                            done_d    = 1'b1;
                            stable_d  = still_c;
                            extinct_d = empty_c;
                            state_d   = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
    end

endmodule

// File: tb/tb_life_grid.sv
// Bench for life_grid: an 8x8 toroidal instance and a 5x5 dead-edge instance,
// each checked every cycle against a behavioural grid model.
module tb_life_grid;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [1:0]       ena, load_valid, start;
    logic [1:0][2:0]  load_row;
    logic [1:0][7:0]  load_data;
    logic [1:0][8:0]  birth, survive;
    logic [1:0][15:0] gen_target;
    logic [63:0]      gq0;
    logic [24:0]      gq1;
    logic [1:0]       busy, done, stable, extinct;
    logic [1:0][15:0] gen_count;

    int checks = 0;
    int failures = 0;

    localparam logic [8:0] CB = 9'b0_0000_1000;
    localparam logic [8:0] CS = 9'b0_0000_1100;

    always #5 clk = ~clk;

    life_grid #(.ROWS(8), .COLS(8), .WRAP(1'b1), .GEN_W(16)) dut_wrap (
        .clk(clk), .rst(rst), .ena(ena[0]), .load_valid(load_valid[0]),
        .load_row(load_row[0]), .load_data(load_data[0]),
        .birth_rule(birth[0]), .survive_rule(survive[0]),
        .gen_target(gen_target[0]), .start(start[0]), .grid_q(gq0),
        .busy(busy[0]), .done(done[0]), .stable(stable[0]),
        .extinct(extinct[0]), .gen_count(gen_count[0])
    );

    life_grid #(.ROWS(5), .COLS(5), .WRAP(1'b0), .GEN_W(16)) dut_dead (
        .clk(clk), .rst(rst), .ena(ena[1]), .load_valid(load_valid[1]),
        .load_row(load_row[1]), .load_data(load_data[1][4:0]),
        .birth_rule(birth[1]), .survive_rule(survive[1]),
        .gen_target(gen_target[1]), .start(start[1]), .grid_q(gq1),
        .busy(busy[1]), .done(done[1]), .stable(stable[1]),
        .extinct(extinct[1]), .gen_count(gen_count[1])
    );

    function automatic int rows_of(input int d);
        return (d == 0) ? 8 : 5;
    endfunction

    function automatic logic [63:0] gq(input int d);
        return (d == 0) ? gq0 : {39'd0, gq1};
    endfunction

    function automatic logic [63:0] mask_of(input int d);
        return (d == 0) ? ~64'd0 : ((64'd1 << 25) - 64'd1);
    endfunction

    // One generation computed straight from the neighbour-count rules.
    function automatic logic [63:0] next_gen(input logic [63:0] g, input int d,
                                             input logic [8:0] b, input logic [8:0] s);
        logic [63:0] nx;
        int n_r, n_c, cnt, rr, cc;
        n_r = rows_of(d);
        n_c = rows_of(d);
        nx = '0;
        for (int r = 0; r < n_r; r++) begin
            for (int c = 0; c < n_c; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr != 0 || dc != 0) begin
                            rr = r + dr;
                            cc = c + dc;
                            if (d == 0) begin
                                rr = (rr + n_r) % n_r;
                                cc = (cc + n_c) % n_c;
                                cnt += int'(g[rr * n_c + cc]);
                            end else if (rr >= 0 && rr < n_r && cc >= 0 && cc < n_c) begin
                                cnt += int'(g[rr * n_c + cc]);
                            end
                        end
                    end
                end
                nx[r * n_c + c] = g[r * n_c + c] ? s[cnt] : b[cnt];
            end
        end
        return nx;
    endfunction

    // Whole run: grid after termination and number of generations committed.
    function automatic logic [63:0] play(input logic [63:0] g, input int d,
                                         input logic [8:0] b, input logic [8:0] s,
                                         input int target, output int gens,
                                         output bit st, output bit ex);
        logic [63:0] nx;
        gens = 0; st = 0; ex = 0;
        for (int i = 0; i < target; i++) begin
            nx = next_gen(g, d, b, s);
            st = (nx == g);
            ex = (nx == 64'd0);
            g = nx;
            gens++;
            if (st || ex) break;
        end
        return g;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-level reference: IDLE loads/starts, RUN commits generations.
    logic [63:0] m_grid[2];
    logic        m_run[2], m_done[2], m_stab[2], m_ext[2];
    logic [15:0] m_gen[2], m_tgt[2];
    logic [8:0]  m_b[2], m_s[2];

    always @(posedge clk or posedge rst) begin
        logic [63:0] nx;
        bit st, ex;
        int row;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_grid[d] = '0; m_run[d] = 0; m_done[d] = 0;
                m_stab[d] = 0; m_ext[d] = 0; m_gen[d] = '0; m_tgt[d] = '0;
                m_b[d] = CB; m_s[d] = CS;
            end else begin
                m_done[d] = 0;
                if (!m_run[d]) begin
                    row = int'(load_row[d]);
                    if (load_valid[d] && row < rows_of(d)) begin
                        for (int c = 0; c < rows_of(d); c++)
                            m_grid[d][row * rows_of(d) + c] = load_data[d][c];
                    end
                    if (start[d]) begin
                        m_run[d] = 1; m_tgt[d] = gen_target[d];
                        m_b[d] = birth[d]; m_s[d] = survive[d];
                        m_gen[d] = '0; m_stab[d] = 0; m_ext[d] = 0;
                    end
                end else if (ena[d]) begin
                    if (m_tgt[d] == 16'd0) begin
                        m_done[d] = 1; m_run[d] = 0;
                    end else begin
                        nx = next_gen(m_grid[d], d, m_b[d], m_s[d]);
                        st = (nx == m_grid[d]);
                        ex = (nx == 64'd0);
                        m_grid[d] = nx;
                        m_gen[d] = m_gen[d] + 16'd1;
                        if (m_gen[d] == m_tgt[d] || st || ex) begin
                            m_done[d] = 1; m_run[d] = 0;
                            m_stab[d] = st; m_ext[d] = ex;
                        end
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d_grid", d), gq(d), m_grid[d]);
            check($sformatf("d%0d_busy", d), 64'(busy[d]), 64'(m_run[d]));
            check($sformatf("d%0d_done", d), 64'(done[d]), 64'(m_done[d]));
            check($sformatf("d%0d_stable", d), 64'(stable[d]), 64'(m_stab[d]));
            check($sformatf("d%0d_extinct", d), 64'(extinct[d]), 64'(m_ext[d]));
            check($sformatf("d%0d_gen", d), 64'(gen_count[d]), 64'(m_gen[d]));
        end
    end

    task automatic load_grid(input int d, input logic [63:0] g, input bit with_start,
                             input logic [15:0] tgt, input logic [8:0] b, input logic [8:0] s);
        for (int r = 0; r < rows_of(d); r++) begin
            @(negedge clk);
            load_valid[d] = 1'b1;
            load_row[d]   = 3'(r);
            load_data[d]  = '0;
            for (int c = 0; c < rows_of(d); c++) load_data[d][c] = g[r * rows_of(d) + c];
            if (with_start && r == rows_of(d) - 1) begin
                gen_target[d] = tgt; birth[d] = b; survive[d] = s;
                ena[d] = 1'b1; start[d] = 1'b1;
            end
        end
        @(negedge clk);
        load_valid[d] = 1'b0;
        start[d] = 1'b0;
    endtask

    task automatic start_run(input int d, input logic [15:0] tgt,
                             input logic [8:0] b, input logic [8:0] s);
        @(negedge clk);
        gen_target[d] = tgt; birth[d] = b; survive[d] = s;
        ena[d] = 1'b1; start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
    endtask

    // Runs until busy drops; optional random ena gaps and ignored host traffic.
    task automatic wait_done(input int d, input int ena_pct, input bit noise, input int max);
        for (int i = 0; i < max; i++) begin
            @(posedge clk);
            #2;
            if (!busy[d]) begin
                ena[d] = 1'b1; load_valid[d] = 1'b0; start[d] = 1'b0;
                return;
            end
            ena[d] = ($urandom_range(99) < ena_pct);
            if (noise) begin
                load_valid[d] = 1'($urandom_range(1));
                load_row[d]   = 3'($urandom);
                load_data[d]  = 8'($urandom);
                start[d]      = ($urandom_range(7) == 0);
            end
        end
        check($sformatf("d%0d_timeout", d), 64'(busy[d]), 64'd0);
        ena[d] = 1'b1; load_valid[d] = 1'b0; start[d] = 1'b0;
    endtask

    localparam logic [63:0] BLINK_H = 64'h3800;        // 5x5 row 2, cols 1-3
    localparam logic [63:0] BLINK_V = 64'h21080;       // 5x5 col 2, rows 1-3
    localparam logic [63:0] GLIDER  = 64'h70402;
    localparam logic [63:0] BLOCK   = 64'h0000_0018_1800_0000;
    localparam logic [63:0] RPENT   = 64'h0000_0008_0C18_0000;

    initial begin
        logic [63:0] g, exp_g;
        int gens, tgt, d;
        bit st, ex, ws;
        logic [8:0] b, s;

        ena = '0; load_valid = '0; start = '0; load_row = '0; load_data = '0;
        birth = '0; survive = '0; gen_target = '0;

        // Pin the model with hand-derived results.
        check("model_blinker", next_gen(BLINK_H, 1, CB, CS), BLINK_V);
        exp_g = play(GLIDER, 0, CB, CS, 32, gens, st, ex);
        check("model_glider", exp_g, GLIDER);

        repeat (3) @(posedge clk);
        #1;
        check("rst_grid", gq0, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_gen", 64'(gen_count[0]), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Blinker, dead edges.
        load_grid(1, BLINK_H, 1'b1, 16'd2, CB, CS);
        @(posedge clk); #1;
        check("blink_gen1", 64'(gq1), BLINK_V);
        wait_done(1, 100, 1'b0, 20);
        check("blink_final", 64'(gq1), BLINK_H);
        check("blink_count", 64'(gen_count[1]), 64'd2);
        check("blink_flags", 64'({stable[1], extinct[1]}), 64'd0);

        // Glider wraps fully round the torus.
        load_grid(0, GLIDER, 1'b0, 16'd0, CB, CS);
        start_run(0, 16'd32, CB, CS);
        wait_done(0, 100, 1'b0, 60);
        check("glider_final", gq0, GLIDER);
        check("glider_count", 64'(gen_count[0]), 64'd32);

        // Still life.
        load_grid(0, BLOCK, 1'b1, 16'd100, CB, CS);
        wait_done(0, 100, 1'b0, 20);
        check("block_count", 64'(gen_count[0]), 64'd1);
        check("block_flags", 64'({stable[0], extinct[0]}), 64'b10);

        // Lone cell dies.
        load_grid(1, 64'h1000, 1'b1, 16'd10, CB, CS);
        wait_done(1, 100, 1'b0, 20);
        check("single_count", 64'(gen_count[1]), 64'd1);
        check("single_flags", 64'({stable[1], extinct[1]}), 64'b01);

        // Empty grid is both still and extinct.
        load_grid(0, 64'd0, 1'b1, 16'd5, CB, CS);
        wait_done(0, 100, 1'b0, 20);
        check("empty_flags", 64'({stable[0], extinct[0]}), 64'b11);
        check("empty_count", 64'(gen_count[0]), 64'd1);

        // Zero-length run ends the cycle after start.
        start_run(0, 16'd0, CB, CS);
        @(posedge clk); #1;
        check("zero_done", 64'({done[0], busy[0]}), 64'b10);
        check("zero_count", 64'(gen_count[0]), 64'd0);
        @(posedge clk); #1;
        check("zero_done_pulse", 64'(done[0]), 64'd0);

        // Pause for five cycles after generation 4.
        load_grid(0, RPENT, 1'b1, 16'd12, CB, CS);
        repeat (4) @(posedge clk);
        #2;
        ena[0] = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        exp_g = play(RPENT, 0, CB, CS, 4, gens, st, ex);
        check("pause_grid", gq0, exp_g);
        check("pause_count", 64'(gen_count[0]), 64'd4);
        ena[0] = 1'b1;
        wait_done(0, 100, 1'b0, 40);
        exp_g = play(RPENT, 0, CB, CS, 12, gens, st, ex);
        check("pause_final", gq0, exp_g);
        check("pause_final_count", 64'(gen_count[0]), 64'(gens));

        // Host writes while running are ignored.
        load_grid(1, 64'h0E_7391 & mask_of(1), 1'b1, 16'd6, CB, CS);
        wait_done(1, 80, 1'b1, 60);

        // Asynchronous reset during generation 3 of 10.
        load_grid(0, GLIDER, 1'b1, 16'd10, CB, CS);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_mid_grid", gq0, 64'd0);
        check("rst_mid_busy", 64'(busy[0]), 64'd0);
        check("rst_mid_count", 64'(gen_count[0]), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Randomised runs on both instances.
        for (int i = 0; i < 30; i++) begin
            d   = i % 2;
            g   = {$urandom, $urandom} & {$urandom, $urandom} & mask_of(d);
            tgt = $urandom_range(0, 30);
            if ($urandom_range(1) == 0) begin
                b = CB; s = CS;
            end else begin
                b = 9'($urandom); s = 9'($urandom);
            end
            ws = 1'($urandom_range(1));
            load_grid(d, g, ws, 16'(tgt), b, s);
            if (!ws) start_run(d, 16'(tgt), b, s);
            wait_done(d, 75, 1'b1, 400);
            exp_g = play(g, d, b, s, tgt, gens, st, ex);
            check($sformatf("rand%0d_grid", i), gq(d), exp_g);
            check($sformatf("rand%0d_count", i), 64'(gen_count[d]), 64'(gens));
        end

        repeat (2) @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/life_grid.md
# life_grid

Parametrised Game of Life engine: a ROWS x COLS register array of cells advancing one generation per enabled clock under runtime-programmable birth/survive rules. Boundary mode is fixed per instance: toroidal wrap or dead edge. A small run FSM runs a requested number of generations and stops early on a still life or extinction. The grid is loaded row-by-row from the host side; completion and status flags go back to the host or display logic.

## Interface
- ROWS, 8, grid height (>= 3)
- COLS, 8, grid width (>= 3)
- WRAP, 1, 1 = toroidal neighbours, 0 = cells outside grid read as dead
- GEN_W, 16, width of generation target/counter
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- ena  in  1  step enable; low in RUN pauses the engine (all state held)
- load_valid  in  1  write load_data into row load_row (IDLE only)
- load_row  in  $clog2(ROWS)  target row index; values >= ROWS ignored
- load_data  in  COLS  row contents, bit c = column c
- birth_rule  in  9  bit n set: dead cell with n live neighbours becomes alive
- survive_rule  in  9  bit n set: live cell with n live neighbours stays alive
- gen_target  in  GEN_W  generations to run, sampled on start
- start  in  1  begin a run (accepted in IDLE only)
- grid_q  out  ROWS*COLS  current grid, bit r*COLS+c
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse when a run ends
- stable  out  1  last run ended because next grid == current grid
- extinct  out  1  last run ended because next grid is all zero
- gen_count  out  GEN_W  generations committed in current/last run

## Operation
- States: IDLE, RUN. Reset -> IDLE; grid_q, busy, done, stable, extinct, gen_count all 0.
- IDLE: load_valid writes row; start latches gen_target, birth_rule, survive_rule; clears gen_count/stable/extinct; -> RUN. Rules are not re-sampled mid-run.
- load_valid and start on the same edge: row write applied, start accepted; first generation uses the loaded grid.
- load_valid while busy: ignored.
- gen_target == 0: start -> RUN -> next cycle done=1, no generation committed, flags 0, -> IDLE.
- RUN with ena=1: next grid computed combinationally from grid_q; committed; gen_count+1. Terminate (done pulse, -> IDLE) on the same commit if gen_count+1 == gen_target, or next == current (stable=1), or next == 0 (extinct=1). Both flags may set together (empty grid).
- RUN with ena=0: nothing changes; done not asserted.
- Neighbour count: 0..8, 4 bits, eight neighbours excluding self; index into rule mask. WRAP=1: row/col indices modulo ROWS/COLS. WRAP=0: out-of-range neighbours = 0.
- Default Conway B3/S23: birth_rule=9'b0_0000_1000, survive_rule=9'b0_0000_1100.

## Timing
- One generation per enabled RUN cycle; grid_q updates on the commit edge.
- start at edge t -> busy high after t; first commit at edge t+1 (if ena=1).
- done high exactly one cycle, coincident with busy falling; stable/extinct/gen_count hold until next start.
- Async rst mid-run: immediate return to reset values; grid contents lost.

## Structure
- Package life_pkg: state enum (IDLE, RUN), RULE_W=9, NBR_W=4, CONWAY_BIRTH / CONWAY_SURVIVE constants.
- Sub-module life_rule_cell: combinational per-cell next state (self, 8 neighbours, two rule masks -> next); instantiated ROWS*COLS times in a generate loop. The grid register, stable/extinct compare, and FSM live in life_grid.

## Test plan
- 5x5 WRAP=0, blinker row 2 cols 1-3, Conway, gen_target=2 -> after gen 1 vertical col 2 rows 1-3; after gen 2 original; done, gen_count=2, flags 0.
- 8x8 WRAP=1, glider at top-left, gen_target=32 -> grid_q equals initial load (wrapped fully); gen_count=32.
- 2x2 block, gen_target=100 -> terminates after 1 commit, stable=1, extinct=0, gen_count=1.
- Single live cell, gen_target=10 -> 1 commit, extinct=1, stable=0; empty grid -> stable=1 and extinct=1.
- ena low for 5 cycles mid-run -> grid_q and gen_count frozen, run resumes and final state matches unpaused run; gen_target=0 -> done next cycle, gen_count=0.
- rst asserted mid-run (gen 3 of 10) -> all outputs 0 immediately, busy=0; load_valid during RUN does not alter grid.
